bool_vec_checker: RTL and testbench
===================================

Name: bool_vec_checker

Overview:
- Hardware stimulus/response engine for the 4-input boolean expression blocks in the boolean library; it takes over the role the hand-written bench plays.
- Walks every input combination of the device under test (DUT) in ascending order and drives it on `stim`. Waits a settle window, samples the DUT output `resp` and builds the captured truth table.
- Compares each sampled bit against a golden truth table and reports pass/fail, mismatch count and the first failing vector.
- Sits beside a bool_expr-style DUT: `stim` bits map to {a,b,c,d} as `stim[3]=a` … `stim[0]=d`, and `resp` connects to `y`.

Parameters:
- NUM_IN, 4, number of DUT inputs; vectors run 0 .. 2^NUM_IN-1.
- SETTLE, 2, cycles `stim` is held before sampling; legal range 1..255.
- GOLDEN, 16'hFF00, expected truth table (width 2^NUM_IN); bit k is the expected `resp` for vector k.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a sweep.
- resp  in  1  DUT output.
- stim  out  NUM_IN  vector applied to the DUT.
- busy  out  1  sweep in progress.
- done  out  1  sweep complete; results valid.
- pass  out  1  sweep had zero mismatches; valid only while `done`=1.
- err_cnt  out  NUM_IN+1  number of mismatching vectors.
- first_fail  out  NUM_IN  index of the lowest failing vector.
- fail_seen  out  1  at least one mismatch recorded.
- tt_cap  out  2^NUM_IN  captured truth table; bit k is the sampled `resp` for vector k.

Behaviour:
- Reset (synchronous, on any edge with `rst`=1, including mid-sweep): state=IDLE; `stim`=0, `busy`=0, `done`=0, `pass`=0, `err_cnt`=0, `first_fail`=0, `fail_seen`=0, `tt_cap`=0; vector and settle counters=0. Reset overrides `start`.
- States: IDLE, APPLY, SAMPLE, DONE.
- IDLE, `start`=1: clear `err_cnt`, `first_fail`, `fail_seen`, `tt_cap`, `pass`, `done`; set vec=0, `stim`=0, `busy`=1; go to APPLY.
- APPLY:
  - `stim`=vec, held constant; the settle counter runs 0..SETTLE-1.
  - On the edge where the counter equals SETTLE-1, go to SAMPLE and clear the counter.
  - APPLY lasts exactly SETTLE cycles.
- SAMPLE (one cycle, `stim` still = vec), at the closing edge:
  - `tt_cap[vec]` <= `resp`.
  - If `resp` != GOLDEN[vec]: `err_cnt`+1. If `fail_seen`=0 at that point, also `first_fail`<=vec and `fail_seen`<=1.
  - If vec = 2^NUM_IN-1: go to DONE, `busy`<=0, `done`<=1, `pass`<=1 only if no mismatch across the whole sweep, including this vector.
  - Otherwise: vec+1, `stim`<=vec+1, go to APPLY.
- Latency: with `start` sampled at edge E0, `done` rises after edge E0 + 2^NUM_IN*(SETTLE+1). Defaults: 48 edges.
- `stim` changes only on the edge leaving SAMPLE (or the start edge); it is never X and never changes inside the settle window.
- DONE:
  - Results and `done` are held indefinitely; `stim` holds the last vector.
  - `start`=1 in DONE restarts exactly as from IDLE: results clear and `done` drops on the same edge.
- `start` while `busy`=1 is ignored; no restart and no counter disturbance.
- `err_cnt` width NUM_IN+1 holds the maximum value 2^NUM_IN with no wrap.
- `resp` is sampled only in SAMPLE; changes on `resp` at any other time have no effect.
- `pass` and `done` are registered outputs, glitch-free.

Test Plan:
- Reset, then `resp` driven = `stim[3]` (the a input), GOLDEN=16'hFF00, pulse `start` -> after 48 cycles `done`=1, `pass`=1, `err_cnt`=0, `fail_seen`=0, `tt_cap`=16'hFF00; `stim` steps 0..15, each value held 3 cycles.
- `resp` tied 0, GOLDEN=16'hFF00 -> `tt_cap`=16'h0000, `err_cnt`=8, `first_fail`=8, `fail_seen`=1, `pass`=0.
- `resp` driven = ~(`stim[3]`) -> `err_cnt`=16 (5'b10000, no wrap), `first_fail`=0, `pass`=0.
- Pulse `start` again at cycle 20 of a sweep -> ignored; `done` still rises at cycle 48 with results identical to an undisturbed run.
- Assert `rst` at cycle 30 of a sweep -> next cycle all outputs 0, state IDLE; a later `start` produces a full correct 48-cycle sweep.
- From DONE (first sweep failing), pulse `start` with `resp` fixed -> same edge `done`=0 and results cleared; second sweep ends `pass`=1, `err_cnt`=0.

Source files
------------

// File: rtl/bool_vec_checker.sv
// Exhaustive stimulus/response checker for small combinational boolean blocks.
// Sweeps every input vector, samples the DUT response and compares it against a golden truth table.
module bool_vec_checker #(
   parameter int                     NUM_IN = 4,
   parameter int                     SETTLE = 2,
   parameter logic [2**NUM_IN-1:0]   GOLDEN = 16'hFF00
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   resp,
   output logic [NUM_IN-1:0]      stim,
   output logic                   busy,
   output logic                   done,
   output logic                   pass,
   output logic [NUM_IN:0]        err_cnt,
   output logic [NUM_IN-1:0]      first_fail,
   output logic                   fail_seen,
   output logic [2**NUM_IN-1:0]   tt_cap
);

   typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;

   localparam logic [7:0]        SETTLE_LAST = 8'(SETTLE - 1);
   localparam logic [NUM_IN-1:0] VEC_LAST    = '1;

   state_t                state, nxt_state;
   logic [NUM_IN-1:0]     vec, nxt_vec;
   logic [7:0]            cnt, nxt_cnt;
   logic                  nxt_busy, nxt_done, nxt_pass, nxt_fail_seen;
   logic [NUM_IN:0]       nxt_err_cnt;
   logic [NUM_IN-1:0]     nxt_first_fail;
   logic [2**NUM_IN-1:0]  nxt_tt_cap;
   logic                  mism;

   // The applied vector is the sweep index itself, so stim is glitch-free by construction.
   assign stim = vec;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         vec        <= '0;
         cnt        <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_cnt    <= '0;
         first_fail <= '0;
         fail_seen  <= 1'b0;
         tt_cap     <= '0;
      end else begin
         state      <= nxt_state;
         vec        <= nxt_vec;
         cnt        <= nxt_cnt;
         busy       <= nxt_busy;
         done       <= nxt_done;
         pass       <= nxt_pass;
         err_cnt    <= nxt_err_cnt;
         first_fail <= nxt_first_fail;
         fail_seen  <= nxt_fail_seen;
         tt_cap     <= nxt_tt_cap;
      end
   end

   always_comb begin
      nxt_state      = state;
      nxt_vec        = vec;
      nxt_cnt        = cnt;
      nxt_busy       = busy;
      nxt_done       = done;
      nxt_pass       = pass;
      nxt_err_cnt    = err_cnt;
      nxt_first_fail = first_fail;
      nxt_fail_seen  = fail_seen;
      nxt_tt_cap     = tt_cap;
      mism           = (resp != GOLDEN[vec]);

      case (state)
         IDLE, DONE: begin
            if (start) begin
               nxt_state      = APPLY;
               nxt_vec        = '0;
               nxt_cnt        = '0;
               nxt_busy       = 1'b1;
               nxt_done       = 1'b0;
               nxt_pass       = 1'b0;
               nxt_err_cnt    = '0;
               nxt_first_fail = '0;
               nxt_fail_seen  = 1'b0;
               nxt_tt_cap     = '0;
            end
         end
         APPLY: begin
            if (cnt == SETTLE_LAST) begin
               nxt_state = SAMPLE;
               nxt_cnt   = '0;
            end else begin
               nxt_cnt = cnt + 8'd1;
            end
         end
         SAMPLE: begin
            nxt_tt_cap[vec] = resp;
            if (mism) begin
               nxt_err_cnt = err_cnt + 1'b1;
               if (!fail_seen) begin
                  nxt_first_fail = vec;
                  nxt_fail_seen  = 1'b1;
               end
            end
            if (vec == VEC_LAST) begin
               nxt_state = DONE;
               nxt_busy  = 1'b0;
               nxt_done  = 1'b1;
               // Includes the mismatch of this final vector, not yet visible in fail_seen.
               nxt_pass  = !(fail_seen || mism);
            end else begin
               nxt_state = APPLY;
               nxt_vec   = vec + 1'b1;
            end
         end
         default: nxt_state = IDLE;
      endcase
   end

endmodule

// File: tb/tb_bool_vec_checker.sv
// Directed bench for bool_vec_checker: resp is derived from stim by a selectable DUT model.
module tb_bool_vec_checker;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        resp;
   logic [3:0]  stim;
   logic        busy, done, pass, fail_seen;
   logic [4:0]  err_cnt;
   logic [3:0]  first_fail;
   logic [15:0] tt_cap;

   int errors = 0;
   int checks = 0;
   int mode   = 0;   // 0: y=a, 1: y=0, 2: y=~a

   assign resp = (mode == 0) ? stim[3] : (mode == 1) ? 1'b0 : ~stim[3];

   always #5 clk = ~clk;

   bool_vec_checker #(.NUM_IN(4), .SETTLE(2), .GOLDEN(16'hFF00)) dut (
      .clk(clk), .rst(rst), .start(start), .resp(resp), .stim(stim),
      .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
      .first_fail(first_fail), .fail_seen(fail_seen), .tt_cap(tt_cap)
   );

   // Pulses start, then follows the sweep edge by edge; optional start poke / reset at edge k.
   task automatic run_sweep(input int poke_at, input int rst_at, output int n);
      int stim_bad, busy_bad, exp_stim;
      stim_bad = 0; busy_bad = 0; n = 0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      checks++;
      if (done !== 1'b0 || busy !== 1'b1 || err_cnt !== 5'd0 || tt_cap !== 16'h0 ||
          fail_seen !== 1'b0 || pass !== 1'b0 || first_fail !== 4'd0 || stim !== 4'd0) begin
         errors++;
         $display("FAIL start_clear: done=%b busy=%b err=%0d tt=%h fs=%b pass=%b ff=%0d stim=%0d",
                  done, busy, err_cnt, tt_cap, fail_seen, pass, first_fail, stim);
      end
      for (int k = 1; k <= 100; k++) begin
         start = (k == poke_at);
         rst   = (k == rst_at);
         @(posedge clk); #1;
         start = 1'b0;
         rst   = 1'b0;
         if (k == rst_at) begin
            n = k;
            break;
         end
         exp_stim = (k < 48) ? k / 3 : 15;
         if (stim !== 4'(exp_stim)) stim_bad++;
         if (busy !== (k < 48)) busy_bad++;
         if (done === 1'b1) begin
            n = k;
            break;
         end
      end
      checks++;
      if (stim_bad != 0) begin
         errors++;
         $display("FAIL stim_seq: %0d edges with wrong stim, required 0", stim_bad);
      end
      checks++;
      if (busy_bad != 0) begin
         errors++;
         $display("FAIL busy_seq: %0d edges with wrong busy, required 0", busy_bad);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++;
      if (stim !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || err_cnt !== 5'd0 ||
          first_fail !== 4'd0 || fail_seen !== 1'b0 || tt_cap !== 16'h0) begin
         errors++;
         $display("FAIL reset_state: stim=%0d busy=%b done=%b pass=%b err=%0d ff=%0d fs=%b tt=%h, required all 0",
                  stim, busy, done, pass, err_cnt, first_fail, fail_seen, tt_cap);
      end
   endtask

   task automatic test_pass_sweep();
      int n;
      mode = 0;
      run_sweep(0, 0, n);
      checks++;
      if (n !== 48) begin errors++; $display("FAIL pass_latency: got %0d edges, required 48", n); end
      checks++;
      if (pass !== 1'b1 || err_cnt !== 5'd0 || fail_seen !== 1'b0 || tt_cap !== 16'hFF00) begin
         errors++;
         $display("FAIL pass_result: pass=%b err=%0d fs=%b tt=%h, required 1 0 0 ff00", pass, err_cnt, fail_seen, tt_cap);
      end
      // Results must hold in DONE and ignore resp changes.
      mode = 2;
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b1 || pass !== 1'b1 || tt_cap !== 16'hFF00 || stim !== 4'd15 || err_cnt !== 5'd0) begin
         errors++;
         $display("FAIL done_hold: done=%b pass=%b tt=%h stim=%0d err=%0d, required 1 1 ff00 15 0",
                  done, pass, tt_cap, stim, err_cnt);
      end
   endtask

   task automatic test_resp_zero();
      int n;
      mode = 1;
      run_sweep(0, 0, n);
      checks++;
      if (n !== 48) begin errors++; $display("FAIL zero_latency: got %0d edges, required 48", n); end
      checks++;
      if (tt_cap !== 16'h0000 || err_cnt !== 5'd8 || first_fail !== 4'd8 || fail_seen !== 1'b1 || pass !== 1'b0) begin
         errors++;
         $display("FAIL zero_result: tt=%h err=%0d ff=%0d fs=%b pass=%b, required 0000 8 8 1 0",
                  tt_cap, err_cnt, first_fail, fail_seen, pass);
      end
   endtask

   task automatic test_all_fail();
      int n;
      mode = 2;
      run_sweep(0, 0, n);
      checks++;
      if (err_cnt !== 5'b10000 || first_fail !== 4'd0 || pass !== 1'b0 || fail_seen !== 1'b1 || tt_cap !== 16'h00FF) begin
         errors++;
         $display("FAIL all_fail: err=%0d ff=%0d pass=%b fs=%b tt=%h, required 16 0 0 1 00ff",
                  err_cnt, first_fail, pass, fail_seen, tt_cap);
      end
   endtask

   task automatic test_start_while_busy();
      int n;
      mode = 0;
      run_sweep(20, 0, n);
      checks++;
      if (n !== 48) begin errors++; $display("FAIL busy_start_latency: got %0d edges, required 48", n); end
      checks++;
      if (pass !== 1'b1 || err_cnt !== 5'd0 || tt_cap !== 16'hFF00) begin
         errors++;
         $display("FAIL busy_start_result: pass=%b err=%0d tt=%h, required 1 0 ff00", pass, err_cnt, tt_cap);
      end
   endtask

   task automatic test_mid_reset();
      int n;
      mode = 1;
      run_sweep(0, 30, n);
      checks++;
      if (n !== 30 || stim !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || err_cnt !== 5'd0 ||
          first_fail !== 4'd0 || fail_seen !== 1'b0 || tt_cap !== 16'h0) begin
         errors++;
         $display("FAIL mid_reset: n=%0d stim=%0d busy=%b done=%b err=%0d ff=%0d fs=%b tt=%h, required n=30 rest 0",
                  n, stim, busy, done, err_cnt, first_fail, fail_seen, tt_cap);
      end
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0 || stim !== 4'd0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: busy=%b stim=%0d done=%b, required 0 0 0", busy, stim, done);
      end
      mode = 0;
      run_sweep(0, 0, n);
      checks++;
      if (n !== 48 || pass !== 1'b1 || err_cnt !== 5'd0 || tt_cap !== 16'hFF00) begin
         errors++;
         $display("FAIL post_reset_sweep: n=%0d pass=%b err=%0d tt=%h, required 48 1 0 ff00", n, pass, err_cnt, tt_cap);
      end
   endtask

   task automatic test_restart_from_done();
      int n;
      mode = 1;
      run_sweep(0, 0, n);
      checks++;
      if (done !== 1'b1 || pass !== 1'b0 || err_cnt !== 5'd8) begin
         errors++;
         $display("FAIL restart_first: done=%b pass=%b err=%0d, required 1 0 8", done, pass, err_cnt);
      end
      mode = 0;
      run_sweep(0, 0, n);  // start edge clearing is checked inside the sweep
      checks++;
      if (n !== 48 || pass !== 1'b1 || err_cnt !== 5'd0 || fail_seen !== 1'b0 || tt_cap !== 16'hFF00) begin
         errors++;
         $display("FAIL restart_second: n=%0d pass=%b err=%0d fs=%b tt=%h, required 48 1 0 0 ff00",
                  n, pass, err_cnt, fail_seen, tt_cap);
      end
   endtask

   initial begin
      @(posedge clk); #1;
      test_reset();
      test_pass_sweep();
      test_resp_zero();
      test_all_fail();
      test_start_while_busy();
      test_mid_reset();
      test_restart_from_done();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
